product_accumulator: RTL and testbench



---
 rtl/amt_mac_pkg.sv | 19 +
 rtl/product_accumulator_sat_adder.sv | 22 ++
 rtl/product_accumulator.sv | 105 ++++++++++
 tb/tb_product_accumulator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/amt_mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | amt_mac_pkg : shared state encoding and default sizes for the MAC    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package amt_mac_pkg;

  localparam int DEF_PROD_W = 8;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_LEN    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : amt_mac_pkg
`default_nettype wire

// File: rtl/product_accumulator_sat_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_adder : unsigned ACC_W-bit adder clamping to all-ones on carry   |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module sat_adder #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b};
  assign ovf      = full_sum[ACC_W];
  assign sum      = ovf ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];

endmodule : sat_adder
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | product_accumulator : saturating dot-product of LEN products,        |
// |                       result presented on a valid/ready port         |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module product_accumulator
  import amt_mac_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN    = DEF_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat
);

  localparam int               CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] prod_ext;
  logic [CNT_W-1:0] cnt;
  logic             sat_flag;
  logic             acc_ovf;
  logic             take;
  logic             last;
  logic             drain;

  assign prod_ext = ACC_W'(in_prod);

  sat_adder #(
    .ACC_W (ACC_W)
  ) u_sat_adder (
    .a   (acc),
    .b   (prod_ext),
    .sum (acc_sum),
    .ovf (acc_ovf)
  );

  // in_ready depends only on the state register, never on in_valid
  assign in_ready = (state != DONE);
  assign take     = in_valid && in_ready;
  assign last     = (cnt == LAST_CNT);
  assign drain    = out_valid && out_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACCUM: if (take)  state_next = last ? DONE : ACCUM;
      DONE:        if (drain) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
    if (clr) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
    end else begin
      state <= state_next;
      if (clr) begin
        // out_sum deliberately kept; it is meaningless while out_valid is low
        acc       <= '0;
        cnt       <= '0;
        sat_flag  <= 1'b0;
        out_valid <= 1'b0;
      end else if (take) begin
        acc      <= acc_sum;
        sat_flag <= sat_flag | acc_ovf;
        if (last) begin
          cnt       <= '0;
          out_sum   <= acc_sum;
          out_sat   <= sat_flag | acc_ovf;
          out_valid <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (drain) begin
        acc       <= '0;
        sat_flag  <= 1'b0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule : product_accumulator
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_product_accumulator : randomized self-checking bench, three DUTs  |
// | Revision               : 1.0                                         |
// +----------------------------------------------------------------------+
module tb_product_accumulator;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  // a: defaults (LEN=4, ACC_W=16); b: ACC_W=9; c: LEN=1
  logic        a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat;
  logic [7:0]  a_in_prod;
  logic [15:0] a_out_sum;
  logic        b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat;
  logic [7:0]  b_in_prod;
  logic [8:0]  b_out_sum;
  logic        c_clr, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_sat;
  logic [7:0]  c_in_prod;
  logic [15:0] c_out_sum;

  product_accumulator dut_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_prod(a_in_prod), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_sat(a_out_sat)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(9), .LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_prod(b_in_prod), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_sat(b_out_sat)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_prod(c_in_prod), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum), .out_sat(c_out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic v, input logic [7:0] p, input logic r);
    if (which == 0) begin
      a_in_valid = v; a_in_prod = p; a_out_ready = r;
    end else begin
      b_in_valid = v; b_in_prod = p; b_out_ready = r;
    end
  endtask

  task automatic sample(input int which, output logic v, output logic [15:0] s,
                        output logic sat, output logic rdy);
    if (which == 0) begin
      v = a_out_valid; s = a_out_sum; sat = a_out_sat; rdy = a_in_ready;
    end else begin
      v = b_out_valid; s = 16'(b_out_sum); sat = b_out_sat; rdy = b_in_ready;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_a_valid: got %0b want 0", a_out_valid); end
    n_cmp++; if (a_out_sum !== 16'd0) begin n_err++; $display("FAIL reset_a_sum: got %0d want 0", a_out_sum); end
    n_cmp++; if (a_out_sat !== 1'b0) begin n_err++; $display("FAIL reset_a_sat: got %0b want 0", a_out_sat); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_a_ready: got %0b want 1", a_in_ready); end
    n_cmp++; if ({b_out_valid, b_out_sat, b_in_ready} !== 3'b001 || b_out_sum !== 9'd0) begin
      n_err++; $display("FAIL reset_b: got v=%0b sat=%0b rdy=%0b sum=%0d want 0 0 1 0",
                        b_out_valid, b_out_sat, b_in_ready, b_out_sum); end
    n_cmp++; if ({c_out_valid, c_out_sat, c_in_ready} !== 3'b001 || c_out_sum !== 16'd0) begin
      n_err++; $display("FAIL reset_c: got v=%0b sat=%0b rdy=%0b sum=%0d want 0 0 1 0",
                        c_out_valid, c_out_sat, c_in_ready, c_out_sum); end
  endtask

  task automatic test_basic();
    logic [7:0] prods [4];
    prods = '{8'd3, 8'd5, 8'd7, 8'd9};
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_prod = prods[i];
      cyc();
      if (i == 2) begin
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %0b want 0", a_out_valid); end
      end
    end
    a_in_valid = 1'b0;
    n_cmp++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b want 1", a_out_valid); end
    n_cmp++; if (a_out_sum !== 16'd24) begin n_err++; $display("FAIL basic_sum: got %0d want 24", a_out_sum); end
    n_cmp++; if (a_out_sat !== 1'b0) begin n_err++; $display("FAIL basic_sat: got %0b want 0", a_out_sat); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL basic_done_ready: got %0b want 0", a_in_ready); end
    cyc();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drop: got %0b want 0", a_out_valid); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle_ready: got %0b want 1", a_in_ready); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_in_valid = !(i == 2 || i == 3);
      a_in_prod  = a_in_valid ? 8'd225 : 8'($urandom);
      cyc();
    end
    for (int h = 0; h < 5; h++) begin
      a_in_valid = 1'b1; a_in_prod = 8'd77;   // must be ignored while the result is held
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_sum !== 16'd900 || a_in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%0b sum=%0d rdy=%0b want 1 900 0",
                          h, a_out_valid, a_out_sum, a_in_ready); end
      cyc();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    cyc();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %0b want 0", a_out_valid); end
    a_out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic [7:0] prods [8];
    prods = '{8'd225, 8'd225, 8'd225, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    b_out_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        b_in_valid = 1'b1; b_in_prod = prods[f*4+i];
        cyc();
      end
      b_in_valid = 1'b0;
      if (f == 0) begin
        n_cmp++; if (b_out_valid !== 1'b1 || b_out_sum !== 9'd511 || b_out_sat !== 1'b1) begin
          n_err++; $display("FAIL sat_frame: got v=%0b sum=%0d sat=%0b want 1 511 1",
                            b_out_valid, b_out_sum, b_out_sat); end
      end else begin
        n_cmp++; if (b_out_valid !== 1'b1 || b_out_sum !== 9'd4 || b_out_sat !== 1'b0) begin
          n_err++; $display("FAIL sat_cleared: got v=%0b sum=%0d sat=%0b want 1 4 0",
                            b_out_valid, b_out_sum, b_out_sat); end
      end
      cyc();
    end
    b_out_ready = 1'b0;
  endtask

  task automatic test_clr();
    logic [7:0] prods [4];
    prods = '{8'd1, 8'd2, 8'd3, 8'd4};
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_prod = 8'd10; cyc();
    a_in_prod = 8'd20; cyc();
    a_in_prod = 8'd30; a_clr = 1'b1; cyc();
    a_clr = 1'b0; a_in_valid = 1'b0;
    n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_err++; $display("FAIL clr_idle: got v=%0b rdy=%0b want 0 1", a_out_valid, a_in_ready); end
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_prod = prods[i]; cyc();
    end
    a_in_valid = 1'b0;
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_sum !== 16'd10 || a_out_sat !== 1'b0) begin
      n_err++; $display("FAIL clr_next_frame: got v=%0b sum=%0d sat=%0b want 1 10 0",
                        a_out_valid, a_out_sum, a_out_sat); end
    cyc();
    a_out_ready = 1'b0;
  endtask

  task automatic test_len1();
    c_out_ready = 1'b0;
    c_in_valid = 1'b1; c_in_prod = 8'd42; cyc();
    c_in_valid = 1'b0;
    n_cmp++; if (c_out_valid !== 1'b1 || c_out_sum !== 16'd42 || c_in_ready !== 1'b0) begin
      n_err++; $display("FAIL len1_done: got v=%0b sum=%0d rdy=%0b want 1 42 0",
                        c_out_valid, c_out_sum, c_in_ready); end
    cyc();
    n_cmp++; if (c_out_valid !== 1'b1) begin n_err++; $display("FAIL len1_hold: got %0b want 1", c_out_valid); end
    c_clr = 1'b1; cyc(); c_clr = 1'b0;
    n_cmp++; if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1) begin
      n_err++; $display("FAIL len1_clr: got v=%0b rdy=%0b want 0 1", c_out_valid, c_in_ready); end
    c_in_valid = 1'b1; c_in_prod = 8'd7; c_out_ready = 1'b1; cyc();
    c_in_valid = 1'b0;
    n_cmp++; if (c_out_valid !== 1'b1 || c_out_sum !== 16'd7 || c_out_sat !== 1'b0) begin
      n_err++; $display("FAIL len1_after_clr: got v=%0b sum=%0d sat=%0b want 1 7 0",
                        c_out_valid, c_out_sum, c_out_sat); end
    cyc();
    c_out_ready = 1'b0;
  endtask

  // Reference: the frame result is the true sum of its products clamped to the
  // accumulator range; saturation is flagged exactly when the true sum exceeds it.
  task automatic test_random(input int which, input int acc_w, input int nframes);
    logic [7:0]  p;
    longint      total, maxv;
    logic [15:0] exp_sum, sum;
    logic        exp_sat, v, sat, rdy;
    int          gap, hold;
    maxv = (longint'(1) << acc_w) - 1;
    for (int f = 0; f < nframes; f++) begin
      total = 0;
      for (int t = 0; t < 4; t++) begin
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin drive(which, 1'b0, 8'($urandom), 1'b0); cyc(); end
        p = 8'($urandom);
        if (acc_w < 16 && $urandom_range(0, 1) == 1) p = 8'($urandom_range(200, 255));
        total += longint'(p);
        drive(which, 1'b1, p, 1'($urandom));   // out_ready before DONE must not matter
        cyc();
        sample(which, v, sum, sat, rdy);
        if (t < 3) begin
          n_cmp++; if (v !== 1'b0 || rdy !== 1'b1) begin
            n_err++; $display("FAIL rand%0d_mid f%0d t%0d: got v=%0b rdy=%0b want 0 1", which, f, t, v, rdy); end
        end
      end
      exp_sat = (total > maxv);
      exp_sum = exp_sat ? 16'(maxv) : 16'(total);
      hold = int'($urandom_range(0, 3));
      for (int h = 0; h <= hold; h++) begin
        drive(which, 1'($urandom), 8'($urandom), 1'b0);
        sample(which, v, sum, sat, rdy);
        n_cmp++; if (v !== 1'b1 || sum !== exp_sum || sat !== exp_sat || rdy !== 1'b0) begin
          n_err++; $display("FAIL rand%0d_result f%0d: got v=%0b sum=%0d sat=%0b rdy=%0b want 1 %0d %0b 0",
                            which, f, v, sum, sat, rdy, exp_sum, exp_sat); end
        if (h < hold) cyc();
      end
      drive(which, 1'b0, 8'd0, 1'b1);
      cyc();
      sample(which, v, sum, sat, rdy);
      n_cmp++; if (v !== 1'b0 || rdy !== 1'b1) begin
        n_err++; $display("FAIL rand%0d_drain f%0d: got v=%0b rdy=%0b want 0 1", which, f, v, rdy); end
      drive(which, 1'b0, 8'd0, 1'b0);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    a_clr = 1'b0; a_in_valid = 1'b0; a_in_prod = 8'd0; a_out_ready = 1'b0;
    b_clr = 1'b0; b_in_valid = 1'b0; b_in_prod = 8'd0; b_out_ready = 1'b0;
    c_clr = 1'b0; c_in_valid = 1'b0; c_in_prod = 8'd0; c_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_clr();
    test_len1();
    test_random(0, 16, 25);
    test_random(1, 9, 25);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_product_accumulator
`default_nettype wire
